msg_tree_tracker: RTL and testbench

Parametrised streaming tracker for the protobuf-style message hierarchy. It consumes a token stream of ENTER, EXIT and LEAF field identifiers, and resolves each one against a runtime-writable node table. It keeps the current message path on a stack of depth MAX_DEPTH, and reports, per token, the matched node, its message type and any error. It sits between the field decoder and the per-message field handlers.

---
 rtl/tree_pkg.sv | 48 ++++
 rtl/msg_tree_lookup.sv | 63 ++++++
 rtl/msg_tree_tracker.sv | 227 ++++++++++++++++++++++
 tb/tb_msg_tree_tracker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared types for the message-tree tracker: token kinds, error codes,
// FSM states, node table entry layout and the node match rule.
package tree_pkg;

  // Entry fields are held at a fixed maximum width so one struct serves
  // every parameterisation; narrower configurations zero-extend.
  localparam int ID_MAX_W   = 16;
  localparam int NODE_MAX_W = 8;
  localparam int MSG_MAX_W  = 8;

  typedef enum logic [1:0] {
    LEAF  = 2'd0,
    ENTER = 2'd1,
    EXIT  = 2'd2
  } tok_kind_t;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    MISS      = 2'd1,
    OVERFLOW  = 2'd2,
    UNDERFLOW = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0]   field_id;
    logic [NODE_MAX_W-1:0] parent;
    logic [MSG_MAX_W-1:0]  msg;
  } node_entry_t;

  localparam node_entry_t null_node_entry = '0;

  function automatic logic node_match(
    input node_entry_t           e,
    input logic [ID_MAX_W-1:0]   id,
    input logic [NODE_MAX_W-1:0] cur
  );
    return (e.field_id != '0)
        && (e.field_id == id)
        && (e.parent == cur);
  endfunction

endpackage

// File: rtl/msg_tree_lookup.sv
// Node table compare unit; serial scan (one entry per cycle) by default,
// single-cycle priority compare with MSG_TREE_PARALLEL_LOOKUP_EN.
// Ports: clk/rst_n/start/busy (serial only), tbl, key_id, key_node,
// hit, idx, done.
module msg_tree_lookup
  import tree_pkg::*;
#(
  parameter int NUM_NODES = 8,
  parameter int NODE_W    = $clog2(NUM_NODES)
) (
`ifndef MSG_TREE_PARALLEL_LOOKUP_EN
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  busy,
`endif
  input  node_entry_t           tbl [NUM_NODES],
  input  logic [ID_MAX_W-1:0]   key_id,
  input  logic [NODE_MAX_W-1:0] key_node,
  output logic                  hit,
  output logic [NODE_W-1:0]     idx,
  output logic                  done
);

`ifdef MSG_TREE_PARALLEL_LOOKUP_EN

  // Walk downward so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (node_match(tbl[i], key_id, key_node)) begin
        hit = 1'b1;
        idx = NODE_W'(i);
      end
    end
  end

  assign done = 1'b1;

`else

  logic [NODE_W-1:0] scan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
    end else if (start) begin
      scan <= '0;
    end else if (busy && !done) begin
      scan <= scan + 1'b1;
    end
  end

  assign hit  = node_match(tbl[scan], key_id, key_node);
  assign idx  = scan;
  // The last entry ends the scan whether or not it hits.
  assign done = busy
             && (hit || scan == NODE_W'(NUM_NODES - 1));

`endif

endmodule

// File: rtl/msg_tree_tracker.sv
// Streaming message-path tracker: resolves ENTER/LEAF/EXIT tokens against
// a writable node table and keeps the current path on a bounded stack.
// Ports: clk, rst_n, tree_clr, cfg_* (table write), tok_* (token in),
// rsp_* (per-token response), cur_node, depth.
// Option: MSG_TREE_PARALLEL_LOOKUP_EN selects single-cycle lookup.
module msg_tree_tracker
  import tree_pkg::*;
#(
  parameter int ID_W      = 5,
  parameter int NUM_NODES = 8,
  parameter int NODE_W    = $clog2(NUM_NODES),
  parameter int MSG_W     = 4,
  parameter int MAX_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tree_clr,
  input  logic                           cfg_we,
  input  logic [NODE_W-1:0]              cfg_addr,
  input  logic [ID_W-1:0]                cfg_field_id,
  input  logic [NODE_W-1:0]              cfg_parent,
  input  logic [MSG_W-1:0]               cfg_msg,
  input  logic                           tok_valid,
  output logic                           tok_ready,
  input  logic [1:0]                     tok_kind,
  input  logic [ID_W-1:0]                tok_id,
  output logic                           rsp_valid,
  output logic                           rsp_hit,
  output logic [NODE_W-1:0]              rsp_node,
  output logic [MSG_W-1:0]               rsp_msg,
  output logic [1:0]                     rsp_err,
  output logic [NODE_W-1:0]              cur_node,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int SW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  state_t            state;
  node_entry_t       tbl [NUM_NODES];
  logic [NODE_W-1:0] stack [MAX_DEPTH];

  logic              discard_q;
  logic              push_q;
  logic              pop_q;
  logic [NODE_W-1:0] push_node_q;

  logic accept;
  logic is_exit;
  logic is_enter;
  logic full_now;

  logic [ID_MAX_W-1:0]   key_id;
  logic [NODE_MAX_W-1:0] key_node;
  logic                  res_enter;
  logic                  res_full;
  logic                  resolve;

  logic              lk_hit;
  logic [NODE_W-1:0] lk_idx;
  logic              lk_done;

  logic [NODE_W-1:0] res_node;
  logic [MSG_W-1:0]  res_msg;
  err_t              res_err;
  logic              res_push;

  assign tok_ready = (state == IDLE) && !cfg_we && !tree_clr;
  assign accept    = tok_valid && tok_ready;
  assign is_exit   = (tok_kind == EXIT);
  assign is_enter  = (tok_kind == ENTER);
  assign full_now  = (depth == DW'(MAX_DEPTH));

  assign cur_node = (depth == '0) ? '0
                  : stack[SW'(depth - 1'b1)];

`ifdef MSG_TREE_PARALLEL_LOOKUP_EN

  assign key_id    = ID_MAX_W'(tok_id);
  assign key_node  = NODE_MAX_W'(cur_node);
  assign res_enter = is_enter;
  assign res_full  = full_now;
  assign resolve   = accept && !is_exit;

`else

  // Search key is frozen at acceptance so a mid-scan tree_clr
  // cannot change what the in-flight lookup compares against.
  logic [ID_MAX_W-1:0]   key_id_q;
  logic [NODE_MAX_W-1:0] key_node_q;
  logic                  enter_q;
  logic                  full_q;

  assign key_id    = key_id_q;
  assign key_node  = key_node_q;
  assign res_enter = enter_q;
  assign res_full  = full_q;
  assign resolve   = (state == SEARCH) && lk_done;

`endif

  msg_tree_lookup #(
    .NUM_NODES (NUM_NODES),
    .NODE_W    (NODE_W)
  ) u_lookup (
`ifndef MSG_TREE_PARALLEL_LOOKUP_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .busy     (state == SEARCH),
`endif
    .tbl      (tbl),
    .key_id   (key_id),
    .key_node (key_node),
    .hit      (lk_hit),
    .idx      (lk_idx),
    .done     (lk_done)
  );

  always_comb begin
    res_node = '0;
    res_msg  = '0;
    res_err  = MISS;
    res_push = 1'b0;
    if (lk_hit) begin
      res_node = lk_idx;
      res_msg  = tbl[lk_idx].msg[MSG_W-1:0];
      res_err  = (res_enter && res_full) ? OVERFLOW : NONE;
      res_push = res_enter && !res_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      depth       <= '0;
      discard_q   <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      push_node_q <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_node    <= '0;
      rsp_msg     <= '0;
      rsp_err     <= NONE;
      for (int i = 0; i < NUM_NODES; i++) begin
        tbl[i] <= null_node_entry;
      end
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stack[i] <= '0;
      end
`ifndef MSG_TREE_PARALLEL_LOOKUP_EN
      key_id_q   <= '0;
      key_node_q <= '0;
      enter_q    <= 1'b0;
      full_q     <= 1'b0;
`endif
    end else begin
      if (tree_clr) begin
        depth <= '0;
        if (state != IDLE) begin
          discard_q <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (cfg_we && cfg_addr != '0) begin
            tbl[cfg_addr].field_id <= ID_MAX_W'(cfg_field_id);
            tbl[cfg_addr].parent   <= NODE_MAX_W'(cfg_parent);
            tbl[cfg_addr].msg      <= MSG_MAX_W'(cfg_msg);
          end
          if (accept) begin
            discard_q <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
`ifndef MSG_TREE_PARALLEL_LOOKUP_EN
            key_id_q   <= ID_MAX_W'(tok_id);
            key_node_q <= NODE_MAX_W'(cur_node);
            enter_q    <= is_enter;
            full_q     <= full_now;
`endif
            if (is_exit) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_hit   <= 1'b0;
              rsp_node  <= '0;
              rsp_msg   <= '0;
              rsp_err   <= (depth == '0) ? UNDERFLOW : NONE;
              pop_q     <= (depth != '0);
            end else begin
              state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          state <= SEARCH;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          if (!discard_q && !tree_clr) begin
            if (push_q) begin
              stack[SW'(depth)] <= push_node_q;
              depth             <= depth + 1'b1;
            end else if (pop_q) begin
              depth <= depth - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (resolve) begin
        state       <= RESP;
        rsp_valid   <= 1'b1;
        rsp_hit     <= lk_hit;
        rsp_node    <= res_node;
        rsp_msg     <= res_msg;
        rsp_err     <= res_err;
        push_q      <= res_push;
        push_node_q <= lk_idx;
      end
    end
  end

endmodule

// File: tb/tb_msg_tree_tracker.sv
// Directed bench for msg_tree_tracker (serial lookup build).
// Two instances share stimulus: MAX_DEPTH=4 (a) and MAX_DEPTH=2 (b).
module tb_msg_tree_tracker;

  localparam int PERSON = 3;
  localparam int PHONE  = 5;
  localparam logic [1:0] K_LEAF  = 2'd0;
  localparam logic [1:0] K_ENTER = 2'd1;
  localparam logic [1:0] K_EXIT  = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       tree_clr;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_field_id;
  logic [2:0] cfg_parent;
  logic [3:0] cfg_msg;
  logic       tok_valid;
  logic [1:0] tok_kind;
  logic [4:0] tok_id;

  logic       a_ready, a_valid, a_hit;
  logic [2:0] a_node, a_cur;
  logic [3:0] a_msg;
  logic [1:0] a_err;
  logic [2:0] a_depth;

  logic       b_ready, b_valid, b_hit;
  logic [2:0] b_node, b_cur;
  logic [3:0] b_msg;
  logic [1:0] b_err;
  logic [1:0] b_depth;

  int n_checks = 0;
  int n_fail   = 0;

  logic       c_hit, bc_hit, bc_valid;
  logic [2:0] c_node, bc_node;
  logic [3:0] c_msg;
  logic [1:0] c_err, bc_err;
  int         lat;

  msg_tree_tracker #(.MAX_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tree_clr(tree_clr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_field_id(cfg_field_id), .cfg_parent(cfg_parent),
    .cfg_msg(cfg_msg), .tok_valid(tok_valid),
    .tok_ready(a_ready), .tok_kind(tok_kind), .tok_id(tok_id),
    .rsp_valid(a_valid), .rsp_hit(a_hit), .rsp_node(a_node),
    .rsp_msg(a_msg), .rsp_err(a_err), .cur_node(a_cur),
    .depth(a_depth)
  );

  msg_tree_tracker #(.MAX_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tree_clr(tree_clr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_field_id(cfg_field_id), .cfg_parent(cfg_parent),
    .cfg_msg(cfg_msg), .tok_valid(tok_valid),
    .tok_ready(b_ready), .tok_kind(tok_kind), .tok_id(tok_id),
    .rsp_valid(b_valid), .rsp_hit(b_hit), .rsp_node(b_node),
    .rsp_msg(b_msg), .rsp_err(b_err), .cur_node(b_cur),
    .depth(b_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] addr,
                           input logic [4:0] id,
                           input logic [2:0] par,
                           input logic [3:0] msg);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_field_id = id;
    cfg_parent = par;
    cfg_msg = msg;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Latency counts cycles after the accepting edge; 99 means timeout.
  task automatic send_tok(input logic [1:0] k,
                          input logic [4:0] id,
                          input int clr_at);
    @(negedge clk);
    tok_kind = k;
    tok_id = id;
    tok_valid = 1'b1;
    #1;
    check("tok_ready", a_ready, 1);
    @(posedge clk);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      tok_valid = 1'b0;
      tree_clr = (n == clr_at);
      if (a_valid) begin
        lat = n;
        c_hit = a_hit; c_node = a_node;
        c_msg = a_msg; c_err = a_err;
        bc_valid = b_valid; bc_hit = b_hit;
        bc_node = b_node; bc_err = b_err;
        break;
      end
    end
    tree_clr = 1'b0;
  endtask

  initial begin : stim
    logic seen;
    rst_n = 1'b0;
    tree_clr = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_field_id = '0;
    cfg_parent = '0;
    cfg_msg = '0;
    tok_valid = 1'b0;
    tok_kind = '0;
    tok_id = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", a_ready, 1);
    check("rst_valid", a_valid, 0);
    check("rst_depth", a_depth, 0);
    check("rst_cur", a_cur, 0);
    check("rst_err", a_err, 0);

    cfg_write(3'd1, 5'd1, 3'd0, 4'(PERSON));
    cfg_write(3'd2, 5'd4, 3'd1, 4'(PHONE));

    send_tok(K_ENTER, 5'd1, 0);
    check("enter_lat", lat, 3);
    check("enter_hit", c_hit, 1);
    check("enter_node", c_node, 1);
    check("enter_msg", c_msg, PERSON);
    check("enter_err", c_err, 0);
    @(negedge clk);
    check("rsp_one_cycle", a_valid, 0);
    check("enter_depth", a_depth, 1);
    check("enter_cur", a_cur, 1);

    send_tok(K_LEAF, 5'd4, 0);
    check("leaf_lat", lat, 4);
    check("leaf_hit", c_hit, 1);
    check("leaf_node", c_node, 2);
    check("leaf_msg", c_msg, PHONE);
    @(negedge clk);
    check("leaf_depth", a_depth, 1);
    check("leaf_hold_node", a_node, 2);

    send_tok(K_EXIT, 5'd0, 0);
    check("exit_lat", lat, 1);
    check("exit_hit", c_hit, 0);
    check("exit_node", c_node, 0);
    check("exit_err", c_err, 0);
    @(negedge clk);
    check("exit_depth", a_depth, 0);

    send_tok(K_LEAF, 5'd4, 0);
    check("miss_lat", lat, 9);
    check("miss_err", c_err, 1);
    check("miss_node", c_node, 0);
    check("miss_hit", c_hit, 0);
    check("miss_msg", c_msg, 0);

    // Write to entry 0 while a token waits: must stall and be dropped.
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 3'd0;
    cfg_field_id = 5'd7;
    cfg_parent = 3'd0;
    cfg_msg = 4'd9;
    tok_valid = 1'b1;
    tok_kind = K_LEAF;
    tok_id = 5'd7;
    #1;
    check("cfg_stall_ready", a_ready, 0);
    @(negedge clk);
    check("cfg_no_accept", a_valid, 0);
    cfg_we = 1'b0;
    tok_valid = 1'b0;
    send_tok(K_LEAF, 5'd7, 0);
    check("addr0_lat", lat, 9);
    check("addr0_err", c_err, 1);

    cfg_write(3'd3, 5'd9, 3'd0, 4'd1);
    cfg_write(3'd4, 5'd9, 3'd3, 4'd2);
    cfg_write(3'd5, 5'd9, 3'd4, 4'd6);
    send_tok(K_ENTER, 5'd9, 0);
    check("ch1_node", c_node, 3);
    send_tok(K_ENTER, 5'd9, 0);
    check("ch2_lat", lat, 6);
    check("ch2_node", c_node, 4);
    send_tok(K_ENTER, 5'd9, 0);
    check("ovf_lat", lat, 7);
    check("ovf_valid", bc_valid, 1);
    check("ovf_err", bc_err, 2);
    check("ovf_hit", bc_hit, 1);
    check("ovf_node", bc_node, 5);
    check("nonovf_err", c_err, 0);
    @(negedge clk);
    check("ovf_depth", b_depth, 2);
    check("ovf_cur", b_cur, 4);
    check("deep_depth", a_depth, 3);
    send_tok(K_EXIT, 5'd0, 0);
    send_tok(K_EXIT, 5'd0, 0);
    @(negedge clk);
    check("pop2_depth", b_depth, 0);
    send_tok(K_EXIT, 5'd0, 0);
    check("udf_err", bc_err, 3);
    @(negedge clk);
    check("udf_depth", b_depth, 0);
    check("udf_cur", b_cur, 0);

    send_tok(K_ENTER, 5'd1, 0);
    @(negedge clk);
    check("pre_clr_depth", a_depth, 1);
    send_tok(K_ENTER, 5'd4, 1);
    check("clr_lat", lat, 4);
    check("clr_hit", c_hit, 1);
    check("clr_node", c_node, 2);
    @(negedge clk);
    check("clr_depth", a_depth, 0);
    check("clr_cur", a_cur, 0);

    // Reset pulse while scanning.
    @(negedge clk);
    tok_kind = K_ENTER;
    tok_id = 5'd1;
    tok_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tok_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("ar_hit", a_hit, 0);
    check("ar_node", a_node, 0);
    check("ar_msg", a_msg, 0);
    check("ar_err", a_err, 0);
    check("ar_depth", a_depth, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      seen |= a_valid;
    end
    check("ar_no_rsp", seen, 0);
    send_tok(K_ENTER, 5'd1, 0);
    check("ar_miss_lat", lat, 9);
    check("ar_miss_err", c_err, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
